// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath bundle for the multi-cycle processor.
// Memory handshake: while the controller is in a memory state it holds MemRead/
// MemWrite and IorD steady; the access completes on the rising edge where
// mem_ready_i=1, and the controller moves on only at that edge.
interface mc_main_ctrl_if;
   logic [5:0]  op_i;
   logic        mem_ready_i;
   logic        PCWrite_o;
   logic        PCWriteCond_o;
   logic        IorD_o;
   logic        MemRead_o;
   logic        MemWrite_o;
   logic        IRWrite_o;
   logic        MemtoReg_o;
   logic        RegDst_o;
   logic        RegWrite_o;
   logic        ALUSrcA_o;
   logic        ExtOp_o;
   logic [1:0]  ALUSrcB_o;
   logic [1:0]  PCSource_o;
   logic [1:0]  ALUOp_o;
   logic [3:0]  state_o;
   logic        instr_done_o;
   logic        illegal_o;
   logic [31:0] instr_count_o;

   // Controller side.
   modport master (
      input  op_i, mem_ready_i,
      output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
             MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ExtOp_o, ALUSrcB_o,
             PCSource_o, ALUOp_o, state_o, instr_done_o, illegal_o, instr_count_o
   );

   // Datapath / observer side.
   modport slave (
      output op_i, mem_ready_i,
      input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
             MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ExtOp_o, ALUSrcB_o,
             PCSource_o, ALUOp_o, state_o, instr_done_o, illegal_o, instr_count_o
   );
endinterface

// File: rtl/mc_main_ctrl.sv
// Main control unit of the multi-cycle processor: Moore FSM sequencing
// fetch/decode/execute/memory/write-back, plus a retired-instruction counter.
// Outputs are decoded combinationally from the state (and mem_ready_i/op_i).
module mc_main_ctrl #(
   parameter logic [5:0] OPC_R   = 6'b000000,
   parameter logic [5:0] OPC_LW  = 6'b100011,
   parameter logic [5:0] OPC_SW  = 6'b101011,
   parameter logic [5:0] OPC_BEQ = 6'b000100,
   parameter logic [5:0] OPC_ORI = 6'b001101,
   parameter logic [5:0] OPC_J   = 6'b000010
) (
   input  logic              clk,
   input  logic              rst,
   mc_main_ctrl_if.master    bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_R_EX   = 4'd6,  S_R_WB   = 4'd7,
      S_BEQ_EX = 4'd8,  S_ORI_EX = 4'd9,  S_ORI_WB = 4'd10, S_JUMP   = 4'd11
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] count_q, count_d;

   logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op;
   logic [1:0]  alu_src_b, pc_source, alu_op;
   logic        done, illegal;
   logic        rdy;
   logic [5:0]  op;

   assign rdy = bus.mem_ready_i;
   assign op  = bus.op_i;

   // Next-state and output decode; reset decodes as FETCH with all enables masked.
   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      ext_op        = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_op        = 2'b00;
      done          = 1'b0;
      illegal       = 1'b0;
      case (rst ? S_FETCH : state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (rdy) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            ext_op    = 1'b1;
            if (op == OPC_LW || op == OPC_SW) state_d = S_MEMADR;
            else if (op == OPC_R)             state_d = S_R_EX;
            else if (op == OPC_BEQ)           state_d = S_BEQ_EX;
            else if (op == OPC_ORI)           state_d = S_ORI_EX;
            else if (op == OPC_J)             state_d = S_JUMP;
            else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            state_d   = (op == OPC_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (rdy) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            done       = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (rdy) begin
               done    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_R_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ_EX: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            done          = 1'b1;
            state_d       = S_FETCH;
         end
         S_ORI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = S_ORI_WB;
         end
         S_ORI_WB: begin
            reg_write = 1'b1;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         done          = 1'b0;
         illegal       = 1'b0;
      end
      count_d = count_q + {31'd0, done};
   end

   // State and retired-instruction counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign bus.PCWrite_o     = pc_write;
   assign bus.PCWriteCond_o = pc_write_cond;
   assign bus.IorD_o        = iord;
   assign bus.MemRead_o     = mem_read;
   assign bus.MemWrite_o    = mem_write;
   assign bus.IRWrite_o     = ir_write;
   assign bus.MemtoReg_o    = mem_to_reg;
   assign bus.RegDst_o      = reg_dst;
   assign bus.RegWrite_o    = reg_write;
   assign bus.ALUSrcA_o     = alu_src_a;
   assign bus.ExtOp_o       = ext_op;
   assign bus.ALUSrcB_o     = alu_src_b;
   assign bus.PCSource_o    = pc_source;
   assign bus.ALUOp_o       = alu_op;
   assign bus.state_o       = state_q;
   assign bus.instr_done_o  = done;
   assign bus.illegal_o     = illegal;
   assign bus.instr_count_o = count_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: per-cycle vector table for a full instruction stream,
// plus hand sequences for reset, mid-instruction reset and counter wrap.
module tb_mc_main_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mc_main_ctrl_if bus ();

   mc_main_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Watchdog: the run is a fixed number of cycles; this only guards a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: timed out at %0t, required finish earlier", $time);
      $fatal(1, "timeout");
   end

   int n_cmp = 0;
   int n_err = 0;

   // ctl bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ExtOp
   // sel bit order: ALUSrcB[1:0] PCSource[1:0] ALUOp[1:0]; flg: instr_done illegal
   logic [10:0] ctl_act;
   logic [5:0]  sel_act;
   logic [1:0]  flg_act;
   assign ctl_act = {bus.PCWrite_o, bus.PCWriteCond_o, bus.IorD_o, bus.MemRead_o,
                     bus.MemWrite_o, bus.IRWrite_o, bus.MemtoReg_o, bus.RegDst_o,
                     bus.RegWrite_o, bus.ALUSrcA_o, bus.ExtOp_o};
   assign sel_act = {bus.ALUSrcB_o, bus.PCSource_o, bus.ALUOp_o};
   assign flg_act = {bus.instr_done_o, bus.illegal_o};

   typedef struct {
      logic        rdy;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [10:0] ctl;
      logic [5:0]  sel;
      logic [1:0]  flg;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_ORI = 6'b001101, OP_J = 6'b000010;
   localparam logic [5:0] OP_BAD = 6'b111111;   // also used where op_i is don't-care

   // Expected control words per state, written out from the state table.
   localparam logic [10:0] C_F_RDY  = 11'b1_0_0_1_0_1_0_0_0_0_0;
   localparam logic [10:0] C_F_STL  = 11'b0_0_0_1_0_0_0_0_0_0_0;
   localparam logic [10:0] C_DEC    = 11'b0_0_0_0_0_0_0_0_0_0_1;
   localparam logic [10:0] C_MADR   = 11'b0_0_0_0_0_0_0_0_0_1_1;
   localparam logic [10:0] C_MRD    = 11'b0_0_1_1_0_0_0_0_0_0_0;
   localparam logic [10:0] C_MWB    = 11'b0_0_0_0_0_0_1_0_1_0_0;
   localparam logic [10:0] C_MWR    = 11'b0_0_1_0_1_0_0_0_0_0_0;
   localparam logic [10:0] C_REX    = 11'b0_0_0_0_0_0_0_0_0_1_0;
   localparam logic [10:0] C_RWB    = 11'b0_0_0_0_0_0_0_1_1_0_0;
   localparam logic [10:0] C_BEQ    = 11'b0_1_0_0_0_0_0_0_0_1_0;
   localparam logic [10:0] C_OEX    = 11'b0_0_0_0_0_0_0_0_0_1_0;
   localparam logic [10:0] C_OWB    = 11'b0_0_0_0_0_0_0_0_1_0_0;
   localparam logic [10:0] C_JMP    = 11'b1_0_0_0_0_0_0_0_0_0_0;
   localparam logic [10:0] C_NONE   = 11'b0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [5:0]  S_FETCH  = 6'b01_00_00;
   localparam logic [5:0]  S_DEC    = 6'b11_00_00;
   localparam logic [5:0]  S_EXTIMM = 6'b10_00_00;
   localparam logic [5:0]  S_ZERO   = 6'b00_00_00;
   localparam logic [5:0]  S_REX    = 6'b00_00_10;
   localparam logic [5:0]  S_BEQ    = 6'b00_01_01;
   localparam logic [5:0]  S_OEX    = 6'b10_00_11;
   localparam logic [5:0]  S_JMP    = 6'b00_10_00;

   task automatic add(input logic rdy, input logic [5:0] op, input logic [3:0] st,
                      input logic [10:0] ctl, input logic [5:0] sel,
                      input logic [1:0] flg, input logic [31:0] cnt);
      vec_t v;
      v.rdy = rdy; v.op = op; v.st = st; v.ctl = ctl; v.sel = sel; v.flg = flg; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare every output against one expected record; call at the negedge.
   task automatic check_all(input string tag, input logic [3:0] st, input logic [10:0] ctl,
                            input logic [5:0] sel, input logic [1:0] flg, input logic [31:0] cnt);
      check({tag, ".state"}, {28'd0, bus.state_o}, {28'd0, st});
      check({tag, ".ctl"},   {21'd0, ctl_act},     {21'd0, ctl});
      check({tag, ".sel"},   {26'd0, sel_act},     {26'd0, sel});
      check({tag, ".flags"}, {30'd0, flg_act},     {30'd0, flg});
      check({tag, ".count"}, bus.instr_count_o,    cnt);
   endtask

   int regwrite_seen;

   initial begin
      // ---- stream: lw, sw, R, ori, beq, j with ready held at 1 ----
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 0);  // lw 0-1-2-3-4
      add(1, OP_LW,  1,  C_DEC,   S_DEC,    2'b00, 0);
      add(1, OP_LW,  2,  C_MADR,  S_EXTIMM, 2'b00, 0);
      add(1, OP_BAD, 3,  C_MRD,   S_ZERO,   2'b00, 0);
      add(1, OP_BAD, 4,  C_MWB,   S_ZERO,   2'b10, 0);
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 1);  // sw 0-1-2-5
      add(1, OP_SW,  1,  C_DEC,   S_DEC,    2'b00, 1);
      add(1, OP_SW,  2,  C_MADR,  S_EXTIMM, 2'b00, 1);
      add(1, OP_BAD, 5,  C_MWR,   S_ZERO,   2'b10, 1);
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 2);  // R 0-1-6-7
      add(1, OP_R,   1,  C_DEC,   S_DEC,    2'b00, 2);
      add(1, OP_BAD, 6,  C_REX,   S_REX,    2'b00, 2);
      add(1, OP_BAD, 7,  C_RWB,   S_ZERO,   2'b10, 2);
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 3);  // ori 0-1-9-10
      add(1, OP_ORI, 1,  C_DEC,   S_DEC,    2'b00, 3);
      add(1, OP_BAD, 9,  C_OEX,   S_OEX,    2'b00, 3);
      add(1, OP_BAD, 10, C_OWB,   S_ZERO,   2'b10, 3);
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 4);  // beq 0-1-8
      add(1, OP_BEQ, 1,  C_DEC,   S_DEC,    2'b00, 4);
      add(1, OP_BAD, 8,  C_BEQ,   S_BEQ,    2'b10, 4);
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 5);  // j 0-1-11
      add(1, OP_J,   1,  C_DEC,   S_DEC,    2'b00, 5);
      add(1, OP_BAD, 11, C_JMP,   S_JMP,    2'b10, 5);
      // ---- stalled lw: 2 stall cycles in FETCH, 3 in MEMRD, 10 cycles total ----
      add(0, OP_BAD, 0,  C_F_STL, S_FETCH,  2'b00, 6);
      add(0, OP_BAD, 0,  C_F_STL, S_FETCH,  2'b00, 6);
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 6);
      add(1, OP_LW,  1,  C_DEC,   S_DEC,    2'b00, 6);
      add(1, OP_LW,  2,  C_MADR,  S_EXTIMM, 2'b00, 6);
      add(0, OP_BAD, 3,  C_MRD,   S_ZERO,   2'b00, 6);
      add(0, OP_BAD, 3,  C_MRD,   S_ZERO,   2'b00, 6);
      add(0, OP_BAD, 3,  C_MRD,   S_ZERO,   2'b00, 6);
      add(1, OP_BAD, 3,  C_MRD,   S_ZERO,   2'b00, 6);
      add(1, OP_BAD, 4,  C_MWB,   S_ZERO,   2'b10, 6);
      // ---- illegal opcode: 2 cycles, not counted ----
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 7);
      add(1, OP_BAD, 1,  C_DEC,   S_DEC,    2'b01, 7);
      // ---- sw stalled in MEMWR (reset is applied from here) ----
      add(1, OP_BAD, 0,  C_F_RDY, S_FETCH,  2'b00, 7);
      add(1, OP_SW,  1,  C_DEC,   S_DEC,    2'b00, 7);
      add(1, OP_SW,  2,  C_MADR,  S_EXTIMM, 2'b00, 7);
      add(0, OP_BAD, 5,  C_MWR,   S_ZERO,   2'b00, 7);

      // ---- reset: 3 cycles with ready=1 ----
      rst = 1'b1;
      bus.mem_ready_i = 1'b1;
      bus.op_i = OP_BAD;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_all("reset", 4'd0, C_NONE, S_FETCH, 2'b00, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // ---- vector table ----
      regwrite_seen = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         bus.mem_ready_i = vecs[i].rdy;
         bus.op_i        = vecs[i].op;
         @(negedge clk);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, vecs[i].sel,
                   vecs[i].flg, vecs[i].cnt);
         if (i >= 23 && i <= 32 && bus.RegWrite_o) regwrite_seen++;
         @(posedge clk); #1;
      end
      check("stall_lw.regwrite_once", regwrite_seen, 1);

      // ---- reset while stalled in MEMWR ----
      rst = 1'b1;
      bus.mem_ready_i = 1'b0;
      @(negedge clk);
      check("midrst.state_before_edge", {28'd0, bus.state_o}, 32'd5);
      check("midrst.memwrite", {31'd0, bus.MemWrite_o}, 32'd0);
      check("midrst.ctl", {21'd0, ctl_act}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check_all("midrst", 4'd0, C_NONE, S_FETCH, 2'b00, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_ready_i = 1'b1;
      @(negedge clk);
      check_all("after_rst", 4'd0, C_F_RDY, S_FETCH, 2'b00, 32'd0);

      // ---- counter wrap: preload all-ones, then retire a j ----
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      check("wrap.preload", bus.instr_count_o, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      bus.op_i = OP_J;
      @(negedge clk);
      check_all("wrap.dec", 4'd1, C_DEC, S_DEC, 2'b00, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      bus.op_i = OP_BAD;
      @(negedge clk);
      check_all("wrap.jump", 4'd11, C_JMP, S_JMP, 2'b10, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      @(negedge clk);
      check("wrap.count", bus.instr_count_o, 32'd0);
      check("wrap.state", {28'd0, bus.state_o}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Main control unit for the multi-cycle processor: a Moore FSM that decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, and produces the 2-bit `ALUOp` code that the ALU control decoder consumes. Memory accesses stall on a ready handshake. A retired-instruction counter is included for debug.

## Interface
- `OPC_R`, default 6'b000000: R-type opcode (addu/subu/add/sub/nor).
- `OPC_LW`, default 6'b100011: lw.
- `OPC_SW`, default 6'b101011: sw.
- `OPC_BEQ`, default 6'b000100: beq.
- `OPC_ORI`, default 6'b001101: ori.
- `OPC_J`, default 6'b000010: j.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op_i` in 6: Instr[31:26], taken from the IR. Valid from DECODE onward.
- `mem_ready_i` in 1: memory completes the current access this cycle.
- `PCWrite_o`, `PCWriteCond_o`, `IorD_o`, `MemRead_o`, `MemWrite_o`, `IRWrite_o`, `MemtoReg_o`, `RegDst_o`, `RegWrite_o`, `ALUSrcA_o`, `ExtOp_o` out 1 each: datapath controls. ExtOp=1 selects sign-extend; ExtOp=0 selects zero-extend.
- `ALUSrcB_o` out 2: 00=B reg, 01=const 4, 10=ext imm, 11=sign-ext imm<<2.
- `PCSource_o` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `ALUOp_o` out 2: 00=add, 01=sub, 10=R-type (funct decides), 11=or.
- `state_o` out 4: current state, for debug.
- `instr_done_o` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal_o` out 1: one-cycle pulse when DECODE sees an unknown opcode.
- `instr_count_o` out 32: count of retired instructions.

## Operation
- The state register is 4 bits. All outputs are combinational from the state, plus `mem_ready_i` and `op_i` where noted. Any signal not listed for a state is 0 in that state.

State list (encoding, asserted signals, next state):
- FETCH (0)
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Asserts IRWrite and PCWrite only when mem_ready_i=1.
  - Next: DECODE when mem_ready_i=1; otherwise stay.
- DECODE (1)
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUOp=00, ExtOp=1.
  - Next by opcode: lw/sw go to MEMADR, R goes to R_EX, beq goes to BEQ_EX, ori goes to ORI_EX, j goes to JUMP.
  - Any other opcode goes to FETCH with illegal_o=1.
- MEMADR (2)
  - Asserts ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtOp=1.
  - Next: MEMRD for lw, MEMWR for sw.
- MEMRD (3)
  - Asserts MemRead=1, IorD=1.
  - Next: MEMWB when mem_ready_i=1; otherwise stay.
- MEMWB (4)
  - Asserts RegDst=0, MemtoReg=1, RegWrite=1.
  - Next: FETCH.
- MEMWR (5)
  - Asserts IorD=1; asserts MemWrite=1 every cycle in the state.
  - Next: FETCH when mem_ready_i=1; otherwise stay.
- R_EX (6)
  - Asserts ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next: R_WB.
- R_WB (7)
  - Asserts RegDst=1, MemtoReg=0, RegWrite=1.
  - Next: FETCH.
- BEQ_EX (8)
  - Asserts ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - Next: FETCH.
- ORI_EX (9)
  - Asserts ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtOp=0.
  - Next: ORI_WB.
- ORI_WB (10)
  - Asserts RegDst=0, MemtoReg=0, RegWrite=1.
  - Next: FETCH.
- JUMP (11)
  - Asserts PCWrite=1, PCSource=10.
  - Next: FETCH.

Unused encodings 12–15:
- All outputs are 0.
- Next state is FETCH.

Instruction completion and counting:
- instr_done_o=1 in the final cycle of each instruction: MEMWB, R_WB, BEQ_EX, ORI_WB, JUMP, and MEMWR when mem_ready_i=1.
- instr_count_o increments by 1 at each edge where instr_done_o=1.
- It wraps from 0xFFFFFFFF to 0. Illegal opcodes are not counted.

## Timing
- Reset:
  - When rst=1 at an edge, the state becomes FETCH and instr_count_o becomes 0.
  - While rst=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite are forced to 0. Mux selects follow FETCH values. instr_done_o=0 and illegal_o=0.
  - Reset mid-instruction abandons the instruction with no write-back.
- Cycles per instruction with mem_ready_i held at 1:
  - lw 5, sw 4, R-type 4, ori 4, beq 3, j 3.
  - An illegal opcode costs 2 cycles.
- Each cycle with mem_ready_i=0 in FETCH, MEMRD or MEMWR adds exactly 1 cycle. While stalled, all outputs hold their stall values.
- op_i is sampled only in DECODE and MEMADR; it may change in any other state.
- No output is registered. Outputs settle combinationally after each state change.

## Test plan
- Reset: hold rst=1 for 3 cycles with mem_ready_i=1.
  - Required: state_o=0, instr_count_o=0, all write-enables 0.
  - After release: the FETCH cycle shows MemRead=1, IRWrite=1, PCWrite=1, ALUOp=00.
- Full instruction stream: lw, sw, R, ori, beq, j with mem_ready_i=1.
  - Required state sequences: lw 0-1-2-3-4; sw 0-1-2-5; R 0-1-6-7; ori 0-1-9-10; beq 0-1-8; j 0-1-11.
  - ALUOp=10 seen only in state 6; ALUOp=11 and ExtOp=0 only in state 9.
  - instr_count_o=6 after j retires.
- Stall: lw with mem_ready_i=0 for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Required: 10 cycles total.
  - IRWrite and PCWrite asserted only in the ready FETCH cycle.
  - RegWrite asserted once.
- Illegal opcode 6'b111111.
  - Required: illegal_o pulses in DECODE; next state FETCH; instr_count_o unchanged.
- Reset mid-instruction: assert rst while in MEMWR with mem_ready_i=0.
  - Required: no MemWrite during reset; FETCH after release; count=0.
- Counter wrap: preload instr_count_o to 0xFFFFFFFF by force, then retire a j.
  - Required: instr_count_o=0.
